sram_latency_model: RTL and testbench

//  Parametrised synchronous SRAM behavioural model; next generation of the 16-bit/18-bit-address board SRAM model.
//  - Fixed asynchronous 60 ns read delay becomes a cycle-accurate read latency RD_LAT.
//  - Bidirectional DQ bus becomes a valid/ready request port plus a response port.
//  - Adds byte-enabled writes and out-of-range address handling.
//  - Sits behind the memory-stage SRAM controller in simulation; exercises controller stall logic.

---
 rtl/sram_latency_model.sv | 172 +++++++++++++++++
 tb/tb_sram_latency_model.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_latency_model.sv
// ---------------------------------------------------------------------------
// sram_latency_model
//   Behavioural synchronous SRAM with a fixed, cycle-accurate read latency.
//   Requests arrive on a valid/ready port; read data returns on a one-cycle
//   rsp_valid pulse RD_LAT cycles after acceptance. Writes are byte-enabled,
//   complete at the acceptance edge and produce no response.
//
// Optional feature macro: SRAM_OOR_ERR_EN
//   defined   : out-of-range reads return 0 with rsp_err=1, out-of-range
//               writes are dropped.
//   undefined : addresses wrap modulo DEPTH, rsp_err is tied 0.
//
// Ports
//   clk, rst             rising-edge clock, async active-high reset
//   req_valid/req_ready  request handshake (accept on valid && ready)
//   req_we               1 = write, 0 = read
//   req_addr             word address
//   req_wdata, req_be    write data and per-byte enables
//   rsp_valid            one-cycle read-data strobe
//   rsp_rdata            read data, holds last value between strobes
//   rsp_err              out-of-range flag, qualified by rsp_valid
// ---------------------------------------------------------------------------
module sram_latency_model #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 18,
    parameter int DEPTH  = 1024,
    parameter int RD_LAT = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err
);

    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH == 2**ADDR_W is still representable.
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      LAT_M1    = 4'(RD_LAT - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RD_WAIT = 2'd1;
    localparam logic [1:0] ST_RD_DONE = 2'd2;

    // Storage is deliberately never reset.
    logic [DATA_W-1:0] mem [DEPTH];

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] snap_q, snap_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              accept;
    logic              rd_accept;
    logic              wr_accept;
    logic              wr_ok;
    logic [ADDR_W:0]   addr_wrap;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] rd_word;
    logic              unused_hi;

    assign req_ready = (state_q != ST_RD_WAIT);
    assign rsp_valid = (state_q == ST_RD_DONE);
    assign rsp_rdata = rdata_q;

    assign accept    = req_valid && req_ready;
    assign rd_accept = accept && !req_we;
    assign wr_accept = accept && req_we && wr_ok;

    // Wrapped index; in-range addresses pass through unchanged.
    assign addr_wrap = {1'b0, req_addr} % DEPTH_EXT;
    assign idx       = addr_wrap[IDX_W-1:0];
    assign unused_hi = ^addr_wrap[ADDR_W:IDX_W];

`ifdef SRAM_OOR_ERR_EN
    logic oor;
    logic snap_err_q, snap_err_d;
    logic err_q, err_d;

    assign oor     = ({1'b0, req_addr} >= DEPTH_EXT);
    assign wr_ok   = !oor;
    assign rd_word = oor ? '0 : mem[idx];
    assign rsp_err = err_q;
`else
    assign wr_ok   = 1'b1;
    assign rd_word = mem[idx];
    assign rsp_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        snap_d  = snap_q;
        rdata_d = rdata_q;
`ifdef SRAM_OOR_ERR_EN
        snap_err_d = snap_err_q;
        err_d      = err_q;
`endif
        case (state_q)
            ST_RD_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_RD_DONE;
                    rdata_d = snap_q;
`ifdef SRAM_OOR_ERR_EN
                    err_d   = snap_err_q;
`endif
                end
            end
            default: begin
                // IDLE and RD_DONE behave identically on a new request;
                // RD_DONE always falls back to IDLE otherwise.
                state_d = ST_IDLE;
                if (rd_accept) begin
                    if (RD_LAT == 1) begin
                        // Zero wait cycles: publish the snapshot directly.
                        state_d = ST_RD_DONE;
                        rdata_d = rd_word;
`ifdef SRAM_OOR_ERR_EN
                        err_d   = oor;
`endif
                    end else begin
                        state_d = ST_RD_WAIT;
                        cnt_d   = LAT_M1;
                        snap_d  = rd_word;
`ifdef SRAM_OOR_ERR_EN
                        snap_err_d = oor;
`endif
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            snap_q  <= '0;
            rdata_q <= '0;
`ifdef SRAM_OOR_ERR_EN
            snap_err_q <= 1'b0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            snap_q  <= snap_d;
            rdata_q <= rdata_d;
`ifdef SRAM_OOR_ERR_EN
            snap_err_q <= snap_err_d;
            err_q      <= err_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            for (int i = 0; i < BE_W; i++) begin
                if (req_be[i]) mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_sram_latency_model.sv
// ---------------------------------------------------------------------------
// tb_sram_latency_model
//   Two instances share clk/rst: index 0 has RD_LAT=3, index 1 has RD_LAT=1.
//   A transaction-level model (array memory + pending-read due cycle) predicts
//   ready/valid/data every cycle; directed sequences add literal expectations.
// ---------------------------------------------------------------------------
module tb_sram_latency_model;

`ifdef SRAM_OOR_ERR_EN
    localparam bit OOR = 1'b1;
`else
    localparam bit OOR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [1:0]        rq_valid = '0;
    logic [1:0]        rq_we    = '0;
    logic [1:0][17:0]  rq_addr  = '0;
    logic [1:0][15:0]  rq_wdata = '0;
    logic [1:0][1:0]   rq_be    = '0;
    logic [1:0]        rs_ready;
    logic [1:0]        rs_valid;
    logic [1:0][15:0]  rs_rdata;
    logic [1:0]        rs_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sram_latency_model #(.DATA_W(16), .ADDR_W(18), .DEPTH(1024), .RD_LAT(3)) dut (
        .clk(clk), .rst(rst),
        .req_valid(rq_valid[0]), .req_ready(rs_ready[0]), .req_we(rq_we[0]),
        .req_addr(rq_addr[0]), .req_wdata(rq_wdata[0]), .req_be(rq_be[0]),
        .rsp_valid(rs_valid[0]), .rsp_rdata(rs_rdata[0]), .rsp_err(rs_err[0])
    );

    sram_latency_model #(.DATA_W(16), .ADDR_W(18), .DEPTH(1024), .RD_LAT(1)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(rq_valid[1]), .req_ready(rs_ready[1]), .req_we(rq_we[1]),
        .req_addr(rq_addr[1]), .req_wdata(rq_wdata[1]), .req_be(rq_be[1]),
        .rsp_valid(rs_valid[1]), .rsp_rdata(rs_rdata[1]), .rsp_err(rs_err[1])
    );

    task automatic check(input string nm, input int k, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%0h want=%0h t=%0t", nm, k, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0] mm [2][1024];
    bit          m_ready [2];
    bit          m_valid [2];
    bit          m_pend  [2];
    bit          m_err   [2];
    bit          m_serr  [2];
    logic [15:0] m_rdata [2];
    logic [15:0] m_snap  [2];
    int          m_due   [2];
    int          cyc = 0;

    function automatic int lat(input int k);
        return (k == 0) ? 3 : 1;
    endfunction

    always @(posedge clk or posedge rst) begin : model
        int  a;
        int  w;
        bit  inr;
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                m_ready[k] = 1'b1; m_valid[k] = 1'b0; m_pend[k] = 1'b0;
                m_rdata[k] = '0;   m_err[k]   = 1'b0;
            end
        end else begin
            cyc++;
            for (int k = 0; k < 2; k++) begin
                if (rq_valid[k] && m_ready[k]) begin
                    a   = int'(rq_addr[k]);
                    inr = (a < 1024);
                    w   = a % 1024;
                    if (rq_we[k]) begin
                        if (inr || !OOR)
                            for (int b = 0; b < 2; b++)
                                if (rq_be[k][b]) mm[k][w][8*b +: 8] = rq_wdata[k][8*b +: 8];
                    end else begin
                        m_pend[k] = 1'b1;
                        m_due[k]  = cyc + lat(k) - 1;
                        if (!inr && OOR) begin m_snap[k] = '0; m_serr[k] = 1'b1; end
                        else begin m_snap[k] = mm[k][w]; m_serr[k] = 1'b0; end
                    end
                end
                m_valid[k] = m_pend[k] && (cyc == m_due[k]);
                if (m_valid[k]) begin
                    m_rdata[k] = m_snap[k];
                    m_err[k]   = m_serr[k];
                    m_pend[k]  = 1'b0;
                end
                m_ready[k] = !m_pend[k];
            end
        end
    end

    // ---------------- per-cycle compare + monitor ----------------
    int          pulses    [2] = '{0, 0};
    int          lowcnt    [2] = '{0, 0};
    int          run_len   [2] = '{0, 0};
    int          last_cyc  [2] = '{0, 0};
    int          prev_cyc  [2] = '{0, 0};
    logic [15:0] last_data [2];
    logic [15:0] prev_data [2];
    logic        last_err  [2];

    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                check("ready", k, 32'(rs_ready[k]), 32'(m_ready[k]));
                check("valid", k, 32'(rs_valid[k]), 32'(m_valid[k]));
                check("rdata", k, 32'(rs_rdata[k]), 32'(m_rdata[k]));
                if (m_valid[k]) check("err", k, 32'(rs_err[k]), 32'(m_err[k]));
                if (!rs_ready[k]) lowcnt[k]++;
                if (rs_valid[k]) begin
                    run_len[k]   = (pulses[k] > 0 && last_cyc[k] == cyc - 1) ? run_len[k] + 1 : 1;
                    pulses[k]++;
                    prev_cyc[k]  = last_cyc[k];
                    prev_data[k] = last_data[k];
                    last_cyc[k]  = cyc;
                    last_data[k] = rs_rdata[k];
                    last_err[k]  = rs_err[k];
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input int k, input bit we, input int addr, input logic [15:0] d,
                         input logic [1:0] be, input bit keep);
        int n = 0;
        rq_we[k] = we; rq_addr[k] = 18'(addr); rq_wdata[k] = d; rq_be[k] = be;
        rq_valid[k] = 1'b1;
        while (!m_ready[k] && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) begin
            total++; bad++;
            $display("FAIL accept_timeout[%0d] got=busy want=ready", k);
        end
        @(posedge clk); #1;
        if (!keep) rq_valid[k] = 1'b0;
    endtask

    task automatic wait_rsp(input int k, input int p0, input int n);
        int t = 0;
        while (pulses[k] < p0 + n && t < 40) begin @(negedge clk); #1; t++; end
        check("rsp_count", k, pulses[k], p0 + n);
    endtask

    task automatic read_chk(input int k, input int addr, input logic [15:0] exp,
                            input string nm);
        int p = pulses[k];
        issue(k, 1'b0, addr, 16'h0, 2'b00, 1'b0);
        wait_rsp(k, p, 1);
        check(nm, k, 32'(last_data[k]), 32'(exp));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int p, lc;
        #2;
        for (int k = 0; k < 2; k++) begin
            check("rst_ready", k, 32'(rs_ready[k]), 32'd1);
            check("rst_valid", k, 32'(rs_valid[k]), 32'd0);
            check("rst_rdata", k, 32'(rs_rdata[k]), 32'd0);
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // write then read, RD_LAT=3: ready low for exactly two cycles
        issue(0, 1'b1, 5, 16'h1234, 2'b11, 1'b0);
        lc = lowcnt[0];
        read_chk(0, 5, 16'h1234, "wr_rd");
        check("ready_low_cycles", 0, lowcnt[0] - lc, 2);

        // byte enables, and be=0 as a no-op
        issue(0, 1'b1, 7, 16'hAAAA, 2'b11, 1'b0);
        issue(0, 1'b1, 7, 16'h5555, 2'b01, 1'b0);
        read_chk(0, 7, 16'hAA55, "byte_en");
        issue(0, 1'b1, 7, 16'hFFFF, 2'b00, 1'b0);
        read_chk(0, 7, 16'hAA55, "be_zero");

        // back-to-back reads with req_valid held
        issue(0, 1'b1, 1, 16'h1111, 2'b11, 1'b1);
        issue(0, 1'b1, 2, 16'h2222, 2'b11, 1'b0);
        p = pulses[0];
        issue(0, 1'b0, 1, 16'h0, 2'b00, 1'b1);
        issue(0, 1'b0, 2, 16'h0, 2'b00, 1'b0);
        wait_rsp(0, p, 2);
        check("b2b_first", 0, 32'(prev_data[0]), 32'h1111);
        check("b2b_second", 0, 32'(last_data[0]), 32'h2222);
        check("b2b_spacing", 0, last_cyc[0] - prev_cyc[0], 3);

        // out-of-range read / write
        issue(0, 1'b1, 0, 16'hBEEF, 2'b11, 1'b0);
        read_chk(0, 1024, OOR ? 16'h0000 : 16'hBEEF, "oor_read");
        check("oor_err", 0, 32'(last_err[0]), OOR ? 32'd1 : 32'd0);
        issue(0, 1'b1, 1025, 16'h0BAD, 2'b11, 1'b0);
        read_chk(0, 1, OOR ? 16'h1111 : 16'h0BAD, "oor_write");

        // reset mid-read: outputs clear immediately, response never appears
        p = pulses[0];
        issue(0, 1'b0, 5, 16'h0, 2'b00, 1'b0);
        #1 rst = 1'b1;
        #1;
        check("abort_ready", 0, 32'(rs_ready[0]), 32'd1);
        check("abort_valid", 0, 32'(rs_valid[0]), 32'd0);
        check("abort_rdata", 0, 32'(rs_rdata[0]), 32'd0);
        #1 rst = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        check("abort_no_rsp", 0, pulses[0], p);
        read_chk(0, 5, 16'h1234, "after_abort");

        // RD_LAT=1: one read per cycle, continuous rsp_valid
        for (int i = 1; i <= 4; i++) issue(1, 1'b1, i, 16'(16'h1000 + i), 2'b11, i != 4);
        p  = pulses[1];
        lc = lowcnt[1];
        for (int i = 1; i <= 4; i++) issue(1, 1'b0, i, 16'h0, 2'b00, i != 4);
        wait_rsp(1, p, 4);
        check("lat1_last", 1, 32'(last_data[1]), 32'h1004);
        check("lat1_run", 1, run_len[1], 4);
        check("lat1_ready_low", 1, lowcnt[1] - lc, 0);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
